// File: rtl/tis_pkg.sv
// Shared types for the output arbiter: data width, signed word and arbiter states.
// Used by out_arbiter, out_arbiter_if and the testbench.
package tis_pkg;

    localparam int DATA_W = 11;

    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

    // Lane index reached by stepping k places from base, wrapping at n.
    function automatic int wrap_idx(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/out_arbiter_if.sv
// Producer-lane and sink signals of the output arbiter.
// The slave modport is the arbiter side; the master modport is the producer/sink side.
interface out_arbiter_if
    import tis_pkg::*;
#(
    parameter int NLANE = 4,
    parameter int W     = DATA_W,
    parameter int CW    = 8,
    parameter int LW    = (NLANE > 1) ? $clog2(NLANE) : 1
);
    logic [NLANE-1:0]        write;
    logic signed [W-1:0]     in [NLANE];
    logic [NLANE-1:0]        read;
    logic                    out_valid;
    logic signed [W-1:0]     out_data;
    logic [LW-1:0]           out_lane;
    logic                    out_ready;
    logic [CW-1:0]           count [NLANE];

    modport slave (
        input  write, in, out_ready,
        output read, out_valid, out_data, out_lane, count
    );

    modport master (
        output write, in, out_ready,
        input  read, out_valid, out_data, out_lane, count
    );
endinterface

// File: rtl/out_fifo2.sv
// Two-entry FIFO for {lane, data} payloads. The head register keeps its last
// value while empty, so the outputs hold steady when nothing is valid.
module out_fifo2 #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic          full,
    output logic [PW-1:0] head_data
);
    logic [PW-1:0] mem0_q, mem1_q;
    logic [1:0]    occ_q;
    logic          pop_ok, push_ok;

    assign valid     = (occ_q != 2'd0);
    assign full      = (occ_q == 2'd2);
    assign head_data = mem0_q;
    assign pop_ok    = pop & valid;
    assign push_ok   = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occ_q == 2'd0) mem0_q <= push_data;
                    else               mem1_q <= push_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) mem0_q <= mem1_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        mem0_q <= mem1_q;
                        mem1_q <= push_data;
                    end else begin
                        mem0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/out_arbiter.sv
// Round-robin arbiter draining NLANE producer lanes into a 2-entry output FIFO.
// Optional per-lane transfer counters are built when OUTARB_COUNT_EN is defined.
module out_arbiter
    import tis_pkg::*;
#(
    parameter int NLANE = 4,
    parameter int W     = DATA_W,
    parameter int CW    = 8
) (
    input logic         clk,
    input logic         rst,
    out_arbiter_if.slave bus
);
    localparam int LW = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int PW = LW + W;

    arb_state_t       state_q, state_d;
    logic [LW-1:0]    grant_q, grant_d;
    logic [LW-1:0]    ptr_q, ptr_d;
    logic [NLANE-1:0] excl_q, excl_d;
    logic [NLANE-1:0] read_q, read_d;
    logic [NLANE-1:0] elig;
    logic             found;
    logic             fifo_valid, fifo_full, pop, push;
    logic [PW-1:0]    head;

    assign pop  = fifo_valid & bus.out_ready;
    assign push = (state_q == ACK);
    // The lane just served is masked for one IDLE cycle: its producer may still hold write.
    assign elig = bus.write & ~excl_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            excl_q  <= '0;
            read_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            excl_q  <= excl_d;
            read_q  <= read_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        excl_d  = '0;
        read_d  = '0;
        found   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full || pop) begin
                    for (int k = 0; k < NLANE; k++) begin
                        if (!found && elig[wrap_idx(int'(ptr_q), k, NLANE)]) begin
                            found   = 1'b1;
                            grant_d = LW'(wrap_idx(int'(ptr_q), k, NLANE));
                        end
                    end
                end
                if (found) begin
                    state_d = ACK;
                    read_d  = {{(NLANE-1){1'b0}}, 1'b1} << grant_d;
                end
            end
            ACK: begin
                state_d = IDLE;
                excl_d  = read_q;
                ptr_d   = (grant_q == LW'(NLANE-1)) ? '0 : grant_q + LW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.read = read_q;

    out_fifo2 #(.PW(PW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({grant_q, bus.in[grant_q]}),
        .pop       (pop),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .head_data (head)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_lane  = head[PW-1:W];
    assign bus.out_data  = head[W-1:0];

`ifdef OUTARB_COUNT_EN
    logic [CW-1:0] cnt_q [NLANE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NLANE; i++) cnt_q[i] <= '0;
        end else if (push) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + CW'(1);
        end
    end

    for (genvar i = 0; i < NLANE; i++) begin : g_cnt
        assign bus.count[i] = cnt_q[i];
    end
`else
    for (genvar i = 0; i < NLANE; i++) begin : g_cnt
        assign bus.count[i] = CW'(0);
    end
`endif
endmodule

// File: tb/tb_out_arbiter.sv
// Scoreboard bench for out_arbiter: directed producer traffic, expected outputs
// queued at stimulus time and checked by an independent output monitor.
module tb_out_arbiter;
    import tis_pkg::*;

    localparam int NL = 4;
    localparam int W  = DATA_W;
    localparam int CW = 8;
`ifdef OUTARB_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    typedef struct {
        int lane;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    out_arbiter_if #(.NLANE(NL), .W(W), .CW(CW)) bus ();

    out_arbiter #(.NLANE(NL), .W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        exp_q[$];
    int          lane_q[NL][$];
    int          grant_log[$];
    int          grant_cyc[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pops     = 0;
    logic [NL-1:0] rd_seen;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Output monitor: every accepted head must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output lane=%0d data=%0d required=none",
                         int'(bus.out_lane), int'(bus.out_data));
            end else begin
                e = exp_q.pop_front();
                check("out_lane", int'(bus.out_lane), e.lane);
                check("out_data", int'(bus.out_data), e.data);
            end
        end
    end

    // One clock: sample read mid-cycle, then apply the producer response after the edge.
    task automatic tick();
        logic [NL-1:0] r;
        logic          rs;
        @(negedge clk);
        r  = bus.read;
        rs = rst;
        if (r != '0) begin
            check("read_onehot", int'($onehot(r)), 1);
            check("grant_has_write", int'(r & ~bus.write), 0);
            if (rs) begin
                for (int i = 0; i < NL; i++) if (r[i]) grant_log.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end
        rd_seen = r;
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            for (int i = 0; i < NL; i++) begin
                if (r[i]) begin
                    if (lane_q[i].size() != 0) bus.in[i] = W'(lane_q[i].pop_front());
                    else                       bus.write[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic send(input int l, input int v);
        if (!bus.write[l]) begin
            bus.in[l]    = W'(v);
            bus.write[l] = 1'b1;
        end else begin
            lane_q[l].push_back(v);
        end
    endtask

    task automatic exp_push(input int l, input int v);
        exp_t e;
        e.lane = l;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && (exp_q.size() != 0 || bus.write != '0); i++) tick();
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        bus.write = '0;
        for (int i = 0; i < NL; i++) lane_q[i].delete();
        rst = 1'b0;
        tick();
        tick();
        grant_log.delete();
        grant_cyc.delete();
        rst = 1'b1;
    endtask

    initial begin
        int p0;
        int order[5];
        bus.write     = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NL; i++) bus.in[i] = '0;

        // Reset values
        tick();
        tick();
        check("rst_read", int'(bus.read), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_lane", int'(bus.out_lane), 0);
        for (int i = 0; i < NL; i++) check("rst_count", int'(bus.count[i]), 0);
        rst = 1'b1;

        // Single lane latency: read in cycle 1, output in cycle 2
        bus.out_ready = 1'b1;
        exp_push(2, -5);
        send(2, -5);
        tick();
        check("lat_read_c0", int'(rd_seen), 0);
        tick();
        check("lat_read_c1", int'(rd_seen), 4);
        check("lat_valid_c2", int'(bus.out_valid), 1);
        check("lat_data_c2", int'(bus.out_data), -5);
        check("lat_lane_c2", int'(bus.out_lane), 2);
        drain("lat", 10);
        check("lat_count2", int'(bus.count[2]), CNT_EN);

        // All lanes requesting: grant order 0,1,2,3,0 every second cycle
        do_reset();
        bus.out_ready = 1'b1;
        send(0, 10);  send(0, 50);
        send(1, 20);  send(2, 30);  send(3, 40);
        exp_push(0, 10); exp_push(1, 20); exp_push(2, 30); exp_push(3, 40); exp_push(0, 50);
        drain("rr", 40);
        order = '{0, 1, 2, 3, 0};
        check("rr_grants", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_order", grant_log[k], order[k]);
        for (int k = 1; k < 5 && k < grant_cyc.size(); k++)
            check("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 2);
        check("rr_count0", int'(bus.count[0]), 2 * CNT_EN);

        // Backpressure, then resume with simultaneous push/pop
        do_reset();
        bus.out_ready = 1'b0;
        send(0, 100); send(1, 200); send(0, 300);
        exp_push(0, 100); exp_push(1, 200); exp_push(0, 300);
        repeat (8) tick();
        check("bp_grants_held", grant_log.size(), 2);
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_head_held", int'(bus.out_data), 100);
        p0 = pops;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("bp_resume", grant_log.size(), 3);
        if (grant_log.size() >= 3) check("bp_resume_lane", grant_log[2], 0);
        drain("bp", 20);
        check("bp_pops", pops - p0, 3);

        // Reset during ACK aborts the transfer
        do_reset();
        bus.out_ready = 1'b1;
        send(1, 77);
        tick();
        check("rack_read", int'(bus.read), 2);
        rst = 1'b0;
        tick();
        tick();
        check("rack_valid", int'(bus.out_valid), 0);
        check("rack_count1", int'(bus.count[1]), 0);
        check("rack_read_cleared", int'(bus.read), 0);
        rst = 1'b1;
        exp_push(1, 77);
        for (int i = 0; i < 6 && grant_log.size() == 0; i++) tick();
        check("rack_reack", grant_log.size(), 1);
        if (grant_log.size() >= 1) check("rack_reack_lane", grant_log[0], 1);
        drain("rack", 10);
        check("rack_count1_after", int'(bus.count[1]), CNT_EN);

        // 257 transfers from lane 3: counter wraps to 1
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send(3, ((i * 37) % 2000) - 1000);
            exp_push(3, ((i * 37) % 2000) - 1000);
        end
        drain("wrap", 1200);
        check("wrap_count3", int'(bus.count[3]), CNT_EN);
        check("wrap_count0", int'(bus.count[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/out_arbiter.md
OUT_ARBITER -- requirements
Module: out_arbiter

Interface
REQ-001 Parameter NLANE, default 4: number of producer lanes (core-complex down-write ports).
REQ-002 Parameter W, default 11: signed data width, matching core accumulator width.
REQ-003 Parameter CW, default 8: per-lane transfer counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 write  input  NLANE  lane i holds a valid value on in[i].
REQ-007 in  input  NLANE x W  unpacked per-lane data, signed.
REQ-008 read  output  NLANE  one-hot acknowledge; lane i value consumed.
REQ-009 out_valid  output  1  FIFO head valid.
REQ-010 out_data  output  W  FIFO head value.
REQ-011 out_lane  output  clog2(NLANE)  source lane of head.
REQ-012 out_ready  input  1  sink accepts head this cycle.
REQ-013 count  output  NLANE x CW  per-lane accepted-value counters (see Configuration).

Function
REQ-014 Producer contract: write[i] and in[i] held stable until a rising edge with read[i]=1; producer drops write[i] no later than the following cycle.
REQ-015 FSM states IDLE and ACK; read is registered and nonzero only in ACK.
REQ-016 IDLE: if any write bit set and FIFO has free slot (occupancy <2, counting a same-cycle pop), grant lowest-index requester at or above round-robin pointer (wrapping), go to ACK.
REQ-017 IDLE with no request or FIFO full: stay IDLE, read=0.
REQ-018 ACK: read[g]=1 for exactly one cycle; at its closing edge push {g, in[g]} into FIFO, pointer := (g+1) mod NLANE, return to IDLE.
REQ-019 The lane granted in ACK is not eligible in the immediately following IDLE cycle.
REQ-020 Latency: write[i] high in cycle 0 with idle FSM and empty FIFO -> read[i] in cycle 1 -> out_valid with that value in cycle 2.
REQ-021 Peak throughput: one value per 2 cycles.
REQ-022 FIFO: 2 entries, {lane, data}; pop when out_valid & out_ready; simultaneous push and pop at full permitted; data passed unmodified, no width change.
REQ-023 out_data/out_lane are don't-care-stable (hold last value) while out_valid=0.
REQ-024 Grant never issued to a lane whose write is low in the granting cycle.

Reset
REQ-025 rst=0 at a rising edge: FSM IDLE, read=0, pointer=0, FIFO empty, out_valid=0, out_data=0, out_lane=0, count all 0.
REQ-026 Reset during ACK aborts the transfer: value not pushed, counter not incremented; producer retains its value.

Configuration
REQ-027 Macro OUTARB_COUNT_EN: defined -> count[i] increments by 1 at each ACK push from lane i, wrapping 2^CW-1 -> 0.
REQ-028 Macro OUTARB_COUNT_EN undefined -> count tied to 0, no counter flops synthesised; all other behaviour identical.

Structure
REQ-029 Shared package tis_pkg holds the data-width constant (11), the signed word typedef, and the arbiter state enum {IDLE, ACK}.
REQ-030 The 2-entry FIFO is a sub-module out_fifo2 parameterised on payload width; arbitration and FSM stay in out_arbiter.

Verification
REQ-031 Single lane: write[2]=1, in[2]=-5, out_ready=1 -> read=0100 in cycle 1, out_valid with out_data=-5, out_lane=2 in cycle 2.
REQ-032 All four lanes request continuously, out_ready=1 -> grant order 0,1,2,3,0 with read pulses every second cycle.
REQ-033 Backpressure: out_ready=0, lanes 0 and 1 request -> two values buffered, third request gets no read until one pop; then read resumes within 2 cycles.
REQ-034 Simultaneous push/pop at full: FIFO full, out_ready=1 during ACK -> occupancy stays 2, no value lost or duplicated.
REQ-035 Reset mid-ACK: rst=0 while read[1]=1 -> FIFO empty, count[1]=0, lane 1 re-acknowledged after release.
REQ-036 With OUTARB_COUNT_EN, 257 transfers from lane 3 (CW=8) -> count[3]=1; without macro count stays 0.
